// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient and result handshake bundle for fir_mac_sequencer.
interface fir_mac_sequencer_if #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 32
);
  logic signed [DW-1:0] x_in;
  logic                 x_valid;
  logic                 x_ready;
  logic                 coef_we;
  logic [1:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_ready;
  logic signed [AW-1:0] y;
  logic                 y_valid;
  logic                 busy;

  modport slave (
    input  x_in, x_valid, coef_we, coef_addr, coef_data,
    output x_ready, coef_ready, y, y_valid, busy
  );

  modport master (
    output x_in, x_valid, coef_we, coef_addr, coef_data,
    input  x_ready, coef_ready, y, y_valid, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed 3-tap FIR: one shared signed MAC walks the taps, one per clock,
// over a sample delay line with a writable coefficient register file.
module fir_mac_sequencer #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int AW   = 32,
  parameter int TAPS = 3
) (
  input logic               CLK,
  input logic               rst,
  fir_mac_sequencer_if.slave bus
);

  typedef enum logic {IDLE, MAC} state_t;

  state_t state, state_next;

  logic [1:0]              k;
  logic signed [AW-1:0]    acc;
  logic signed [DW-1:0]    d [TAPS];
  logic signed [CW-1:0]    h [TAPS];
  logic signed [AW-1:0]    y_q;
  logic                    y_valid_q;

  logic                    accept;
  logic                    coef_wr;
  logic                    last_tap;
  logic signed [CW-1:0]    tap_h;
  logic signed [DW-1:0]    tap_d;
  logic signed [DW+CW-1:0] prod;
  logic signed [AW-1:0]    mac_sum;

  always_ff @(posedge CLK) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    coef_wr    = 1'b0;
    last_tap   = 1'b0;
    unique case (state)
      IDLE: begin
        coef_wr = bus.coef_we && (bus.coef_addr != 2'd3);
        if (bus.x_valid) begin
          accept     = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        if (k == 2'd2) begin
          last_tap   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tap_h = '0;
    tap_d = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (k == 2'(i)) begin
        tap_h = h[i];
        tap_d = d[i];
      end
    end
    prod    = (DW+CW)'(tap_h) * (DW+CW)'(tap_d);
    mac_sum = acc + AW'(prod);
  end

  // Coefficient writes share the accept edge, so a same-cycle write is seen by the new sequence.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      k         <= '0;
      acc       <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      y_valid_q <= 1'b0;
      for (int unsigned i = 0; i < TAPS; i++) begin
        if (coef_wr && (bus.coef_addr == 2'(i))) h[i] <= bus.coef_data;
      end
      if (accept) begin
        d[0] <= bus.x_in;
        for (int unsigned i = 1; i < TAPS; i++) d[i] <= d[i-1];
        acc <= '0;
        k   <= '0;
      end else if (state == MAC) begin
        if (last_tap) begin
          y_q       <= mac_sum;
          y_valid_q <= 1'b1;
          k         <= '0;
        end else begin
          acc <= mac_sum;
          k   <= k + 2'd1;
        end
      end
    end
  end

  assign bus.x_ready    = (state == IDLE);
  assign bus.coef_ready = (state == IDLE);
  assign bus.busy       = (state == MAC);
  assign bus.y          = y_q;
  assign bus.y_valid    = y_valid_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with hand-computed filter outputs.
module tb_fir_mac_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   yv_cnt;
  int   cnt0;

  fir_mac_sequencer_if #(.DW(16), .CW(16), .AW(32)) bus ();

  fir_mac_sequencer #(.DW(16), .CW(16), .AW(32), .TAPS(3)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial yv_cnt = 0;
  always @(posedge clk) if (bus.y_valid === 1'b1) yv_cnt <= yv_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wcoef(input logic [1:0] a, input logic [15:0] v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = v;
    step();
    bus.coef_we   = 1'b0;
  endtask

  // Presents one sample from IDLE and follows it cycle by cycle to its result.
  task automatic feed(input logic [15:0] s, input logic [31:0] exp_y, input bit hold,
                      input bit mac_we, input logic [1:0] mac_addr, input logic [15:0] mac_data,
                      input string tag);
    logic [31:0] y_prev;
    bus.x_in    = s;
    bus.x_valid = 1'b1;
    check({tag, ".ready_pre"}, 32'(bus.x_ready), 32'd1);
    y_prev = bus.y;
    step();
    bus.coef_we   = mac_we;
    bus.coef_addr = mac_addr;
    bus.coef_data = mac_data;
    for (int c = 0; c < 3; c++) begin
      check({tag, ".busy_mac"}, 32'(bus.busy), 32'd1);
      check({tag, ".ready_mac"}, 32'(bus.x_ready), 32'd0);
      check({tag, ".yv_mac"}, 32'(bus.y_valid), 32'd0);
      check({tag, ".y_hold"}, bus.y, y_prev);
      step();
    end
    bus.coef_we = 1'b0;
    check({tag, ".yv"}, 32'(bus.y_valid), 32'd1);
    check({tag, ".y"}, bus.y, exp_y);
    check({tag, ".ready_post"}, 32'(bus.x_ready), 32'd1);
    check({tag, ".busy_post"}, 32'(bus.busy), 32'd0);
    if (!hold) bus.x_valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.x_in      = '0;
    bus.x_valid   = 1'b0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    step();
    step();
    check("rst.y", bus.y, 32'd0);
    check("rst.yv", 32'(bus.y_valid), 32'd0);
    check("rst.x_ready", 32'(bus.x_ready), 32'd1);
    check("rst.coef_ready", 32'(bus.coef_ready), 32'd1);
    check("rst.busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    step();

    // Back-to-back samples, h = (-3, 3, 5)
    wcoef(2'd0, 16'hFFFD);
    wcoef(2'd1, 16'd3);
    wcoef(2'd2, 16'd5);
    feed(16'hFFFF, 32'd3,          1'b1, 1'b0, 2'd0, 16'd0, "t1a");
    feed(16'hFFFE, 32'd3,          1'b1, 1'b0, 2'd0, 16'd0, "t1b");
    feed(16'd3,    32'hFFFF_FFEC,  1'b1, 1'b0, 2'd0, 16'd0, "t1c");
    feed(16'd4,    32'hFFFF_FFF3,  1'b0, 1'b0, 2'd0, 16'd0, "t1d");

    // Backpressure: x_valid held through MAC, exactly one accept
    feed(16'd7, 32'd6, 1'b0, 1'b0, 2'd0, 16'd0, "t2");
    step();
    cnt0 = yv_cnt;
    repeat (5) step();
    check("t2.single_accept", 32'(yv_cnt), 32'(cnt0));
    check("t2.y_held", bus.y, 32'd6);

    // Coefficient write rules; d = (7,4,3) before this
    feed(16'd1, 32'd38, 1'b0, 1'b1, 2'd0, 16'd7, "t3a");
    wcoef(2'd3, 16'd9);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd1;
    bus.coef_data = 16'd1;
    feed(16'd2, 32'd30, 1'b0, 1'b0, 2'd0, 16'd0, "t3c");

    // Wrap modulo 2^32 with most-negative operands; d = (2,1,7) before this
    wcoef(2'd0, 16'h8000);
    wcoef(2'd1, 16'h8000);
    wcoef(2'd2, 16'h8000);
    feed(16'h8000, 32'h3FFE_8000, 1'b1, 1'b0, 2'd0, 16'd0, "t4a");
    feed(16'h8000, 32'h7FFF_0000, 1'b1, 1'b0, 2'd0, 16'd0, "t4b");
    feed(16'h8000, 32'hC000_0000, 1'b0, 1'b0, 2'd0, 16'd0, "t4c");

    // Reset while k==1
    bus.x_in    = 16'd5;
    bus.x_valid = 1'b1;
    step();
    bus.x_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("t5.x_ready", 32'(bus.x_ready), 32'd1);
    check("t5.busy", 32'(bus.busy), 32'd0);
    check("t5.y", bus.y, 32'd0);
    check("t5.yv", 32'(bus.y_valid), 32'd0);
    rst  = 1'b1;
    cnt0 = yv_cnt;
    repeat (4) step();
    check("t5.no_pulse", 32'(yv_cnt), 32'(cnt0));
    wcoef(2'd0, 16'hFFFD);
    wcoef(2'd1, 16'd3);
    wcoef(2'd2, 16'd5);
    feed(16'd2, 32'hFFFF_FFFA, 1'b0, 1'b0, 2'd0, 16'd0, "t5b");

    // Sub-cycle reset glitches between edges must not disturb anything
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    step();
    check("t6.idle_y", bus.y, 32'hFFFF_FFFA);
    check("t6.idle_ready", 32'(bus.x_ready), 32'd1);
    bus.x_in    = 16'd1;
    bus.x_valid = 1'b1;
    step();
    bus.x_valid = 1'b0;
    #2 rst = 1'b0;
    #3 rst = 1'b1;
    step();
    check("t6.mac_busy", 32'(bus.busy), 32'd1);
    step();
    step();
    check("t6.yv", 32'(bus.y_valid), 32'd1);
    check("t6.y", bus.y, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Time-multiplexed 3-tap FIR controller. A single shared signed multiplier-accumulator is sequenced over the taps, one tap per clock, against a 3-entry sample delay line. Coefficients live in a writable register file, so the upstream configuration logic no longer drives static h0/h1/h2 buses. It sits between the sample source (valid/ready) and the filter output consumer, and replaces a fully parallel 3-multiplier datapath where area matters.

Parameters:
DW, 16, sample width (signed, two's complement)
CW, 16, coefficient width (signed)
AW, 32, accumulator/output width (signed); must be >= DW+CW
TAPS, 3, number of taps; fixed at 3 for this revision (coef_addr is 2 bits)

Ports:
CLK  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset: sampled on CLK rising edge, rst==0 resets
x_in  in  DW  input sample, signed
x_valid  in  1  x_in valid
x_ready  out  1  block can accept a sample this cycle
coef_we  in  1  coefficient write strobe
coef_addr  in  2  tap index 0..2; value 3 is ignored
coef_data  in  CW  coefficient value, signed
coef_ready  out  1  coefficient writes are honoured this cycle
y  out  AW  filter output, signed, held until the next result
y_valid  out  1  one-cycle pulse: y updated this cycle
busy  out  1  MAC sequence in progress

Behaviour:
- State: IDLE, MAC. Tap counter k (2 bits), accumulator acc (AW), delay line d0..d2 (DW), coefficients h0..h2 (CW).
- Reset (rst==0 at an edge): state=IDLE, k=0, acc=0, d0..d2=0, h0..h2=0, y=0, y_valid=0. Reset overrides all other inputs that cycle.
- Reset mid-MAC abandons the sequence: no y_valid pulse, and the delay line is cleared.
- x_ready = coef_ready = (state==IDLE). busy = (state==MAC). All three are combinational from state.
- Accept (IDLE, x_valid=1, edge E0):
  - d0<=x_in, d1<=d0, d2<=d1.
  - acc<=0, k<=0, state<=MAC.
- MAC, k=0 or 1: acc<=acc+h[k]*d[k], k<=k+1.
- MAC, k=2:
  - y<=acc+h2*d2, y_valid<=1, state<=IDLE, k<=0.
  - Timing: y_valid is high in the cycle after edge E0+3, i.e. latency is 3 clocks from the accept edge.
- y_valid is registered and high for exactly one cycle. In that same cycle the block is IDLE, so a new sample may be accepted. Peak throughput is one sample per 4 clocks.
- x_valid during MAC: not accepted. The source must hold x_in/x_valid. Each sample is accepted exactly once.
- Arithmetic:
  - Operands are sign-extended to AW; the product is full-precision DW+CW, sign-extended.
  - Accumulation wraps modulo 2^AW: no saturation, no overflow flag.
- Coefficient writes:
  - In IDLE with coef_we=1 and coef_addr<=2: h[coef_addr]<=coef_data at that edge.
  - coef_addr==3: no effect.
  - In MAC: coef_we is ignored (coefficients are stable for a whole sequence).
  - Simultaneous IDLE accept and coef write: both occur, and the MAC sequence uses the newly written coefficient.
- No other outputs change during MAC; y holds its previous value until the k=2 edge.

Test Plan:
1. Reset, write h0=-3, h1=3, h2=5. Feed -1, -2, 3, 4 back-to-back (x_valid held) -> y_valid pulses give y = 3, 3, -20, -13. Consecutive accepts are exactly 4 clocks apart, and y_valid comes 3 clocks after each accept.
2. Backpressure: hold x_valid=1 with x_in=7 through a MAC sequence -> x_ready=0 for 3 cycles and only one accept occurs. With h=(-3,3,5) and prior d=(4,3,-2), the next y = -21+12+15 = 6.
3. Write h0=7 during MAC -> ignored, y uses h0=-3. Write coef_addr=3, data=9 in IDLE -> h0..h2 unchanged. Write h1=1 in the same IDLE cycle as an accept -> that result uses h1=1.
4. Wrap: h0=h1=h2=0x8000, feed three samples of 0x8000 -> third y = 0xC0000000 (3*2^30 mod 2^32, i.e. -1073741824).
5. Assert rst=0 in the MAC cycle with k=1 -> next cycle: IDLE, x_ready=1, y=0, y_valid never pulses. A new sample x=2 with h reloaded to (-3,3,5) gives y=-6 (the delay line was cleared).
6. Reset is synchronous: rst=0 pulse lasting less than one clock and not spanning a rising edge -> no state change.
